// File: rtl/alu_sequencer.sv
// Sequences one operation at a time through an external ALU: registers the request,
// waits the settle time, captures the result and holds it until the consumer takes it.
module alu_sequencer #(
  parameter int REG_SIZE    = 32,
  parameter int MULDIV_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [REG_SIZE-1:0]   req_a,
  input  logic [REG_SIZE-1:0]   req_b,
  output logic [3:0]            alu_ctrl,
  output logic [REG_SIZE-1:0]   alu_a,
  output logic [REG_SIZE-1:0]   alu_b,
  input  logic [2*REG_SIZE-1:0] alu_c,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_SIZE-1:0]   rsp_lo,
  output logic [REG_SIZE-1:0]   rsp_hi,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  rsp_dz,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_WAIT - 1);

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

  state_t                state_r;
  state_t                next_state_s;
  logic [3:0]            cnt_r;
  logic [3:0]            ctrl_r;
  logic [REG_SIZE-1:0]   a_r;
  logic [REG_SIZE-1:0]   b_r;
  logic [REG_SIZE-1:0]   lo_r;
  logic [REG_SIZE-1:0]   hi_r;
  logic                  zero_r;
  logic                  err_r;
  logic                  dz_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  accept_s;
  logic                  capture_s;
  logic [REG_SIZE-1:0]   cap_lo_s;
  logic [REG_SIZE-1:0]   cap_hi_s;

  assign accept_s  = req_valid && (state_r == IDLE);
  assign capture_s = (state_r == RUN) && (cnt_r == 4'd0);

  // req_ready must already be high in the first cycle after reset release
  assign req_ready = rst_n && (state_r == IDLE);
  assign alu_ctrl  = ctrl_r;
  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign rsp_lo    = lo_r;
  assign rsp_hi    = hi_r;
  assign rsp_zero  = zero_r;
  assign rsp_err   = err_r;
  assign rsp_dz    = dz_r;
  assign rsp_valid = valid_r;
  assign busy      = busy_r;

  // Next-state logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (is_illegal(req_op)) begin
            next_state_s = DONE;
          end else begin
            next_state_s = RUN;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 4'd0) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Upper result half only carries meaning for mul/div
  always_comb begin
    cap_lo_s = alu_c[REG_SIZE-1:0];
    if (is_muldiv(ctrl_r)) begin
      cap_hi_s = alu_c[2*REG_SIZE-1:REG_SIZE];
    end else begin
      cap_hi_s = {REG_SIZE{1'b0}};
    end
  end

  // State register with registered status flags derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      valid_r <= (next_state_s == DONE);
    end
  end

  // Settle counter: loaded at acceptance, counts down while in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= is_muldiv(req_op) ? WAIT_LOAD : 4'd0;
    end else if ((state_r == RUN) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Operand registers drive the ALU and only change on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= 4'd0;
      a_r    <= {REG_SIZE{1'b0}};
      b_r    <= {REG_SIZE{1'b0}};
    end else if (accept_s) begin
      ctrl_r <= req_op;
      a_r    <= req_a;
      b_r    <= req_b;
    end else begin
      ctrl_r <= ctrl_r;
      a_r    <= a_r;
      b_r    <= b_r;
    end
  end

  // Response registers: illegal ops answer immediately, legal ops at capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_r   <= {REG_SIZE{1'b0}};
      hi_r   <= {REG_SIZE{1'b0}};
      zero_r <= 1'b0;
      err_r  <= 1'b0;
      dz_r   <= 1'b0;
    end else if (accept_s && is_illegal(req_op)) begin
      lo_r   <= {REG_SIZE{1'b0}};
      hi_r   <= {REG_SIZE{1'b0}};
      zero_r <= 1'b1;
      err_r  <= 1'b1;
      dz_r   <= 1'b0;
    end else if (capture_s) begin
      lo_r   <= cap_lo_s;
      hi_r   <= cap_hi_s;
      zero_r <= ({cap_hi_s, cap_lo_s} == {(2*REG_SIZE){1'b0}});
      err_r  <= 1'b0;
      dz_r   <= (ctrl_r == OP_DIV) && (b_r == {REG_SIZE{1'b0}});
    end else begin
      lo_r   <= lo_r;
      hi_r   <= hi_r;
      zero_r <= zero_r;
      err_r  <= err_r;
      dz_r   <= dz_r;
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter REG_SIZE, default 32, operand width; the ALU result width is 2*REG_SIZE.
REQ-002 Parameter MULDIV_WAIT, default 4, range 1-15, settle cycles granted to mul (1000) and div (1001).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  operation request.
REQ-007 req_ready  out  1  sequencer can accept a request.
REQ-008 req_op  in  4  ALU opcode (0000 and ... 1011 not).
REQ-009 req_a / req_b  in  REG_SIZE each  operands.
REQ-010 alu_ctrl  out  4  drives the ALU control signal.
REQ-011 alu_a / alu_b  out  REG_SIZE each  drive the ALU operand inputs.
REQ-012 alu_c  in  2*REG_SIZE  ALU result.
REQ-013 rsp_valid  out  1  result available.
REQ-014 rsp_ready  in  1  consumer takes the result.
REQ-015 rsp_lo / rsp_hi  out  REG_SIZE each  captured result, low and high halves.
REQ-016 rsp_zero  out  1  {rsp_hi,rsp_lo} == 0.
REQ-017 rsp_err  out  1  illegal opcode (1100-1111).
REQ-018 rsp_dz  out  1  div issued with b == 0.
REQ-019 busy  out  1  state != IDLE.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-021 req_ready SHALL be 1 only in IDLE, so at most one operation is in flight.
REQ-022 In IDLE, when req_valid and req_ready are both 1 at a clk edge, the block SHALL register op, a and b.
- Legal op: go to RUN.
- Illegal op: go directly to DONE with rsp_err=1, result 0 and rsp_dz=0.
REQ-023 alu_ctrl, alu_a and alu_b SHALL be driven from registers and held constant from acceptance until capture.
- In IDLE they SHALL hold their last values.
REQ-024 On acceptance, the wait counter SHALL load MULDIV_WAIT-1 for mul/div and 0 for all other ops.
REQ-025 In RUN, the counter SHALL decrement each cycle while nonzero.
- At the edge where it is 0, the block SHALL capture the result and go to DONE.
REQ-026 Acceptance at edge N SHALL raise rsp_valid after edge N+1 for simple ops and after edge N+MULDIV_WAIT for mul/div.
REQ-027 Capture for mul/div: rsp_lo=alu_c[REG_SIZE-1:0], rsp_hi=alu_c[2*REG_SIZE-1:REG_SIZE].
REQ-028 Capture for all other ops: rsp_lo=alu_c[REG_SIZE-1:0] and rsp_hi=0, regardless of the upper alu_c bits.
REQ-029 rsp_zero SHALL be registered at capture from the values actually stored in rsp_hi/rsp_lo.
REQ-030 rsp_dz SHALL be set at capture when op==1001 and b==0; the ALU result is still captured unchanged.
REQ-031 In DONE, rsp_valid=1 and all rsp_* outputs SHALL hold stable until rsp_ready=1 at a clk edge; the block then returns to IDLE.
REQ-032 rsp_valid SHALL drop in the cycle after the handshake.
- No request is accepted in that same edge; the earliest next acceptance is one cycle later.
REQ-033 req_valid asserted outside IDLE SHALL be ignored and SHALL NOT corrupt the registered operands.
REQ-034 rsp_ready asserted outside DONE SHALL have no effect.

Reset
REQ-035 rst_n=0 SHALL asynchronously force:
- state=IDLE, counter=0;
- alu_ctrl=0, alu_a=0, alu_b=0;
- rsp_lo=0, rsp_hi=0, rsp_valid=0, rsp_err=0, rsp_dz=0, rsp_zero=0, busy=0.
REQ-036 Reset in RUN or DONE SHALL abort the operation with no response produced.
REQ-037 req_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.

Verification
REQ-038 Add: op=0010, a=5, b=7 -> rsp_valid one cycle after acceptance, rsp_lo=12, rsp_hi=0, rsp_zero=0.
REQ-039 Mul: op=1000, a=0xFFFFFFFF, b=2, MULDIV_WAIT=4 -> rsp_valid after 4 cycles, {hi,lo}=0xFFFFFFFF_FFFFFFFE (signed -2).
REQ-040 Rotate with dirty upper bits: op=0110, a=1, b=1, alu_c upper half driven 0xDEADBEEF -> rsp_lo=0x80000000, rsp_hi=0.
REQ-041 Illegal op and zero result:
- op=1101 -> rsp_valid one cycle after acceptance, rsp_err=1, result 0, ALU result ignored.
- op=0011, a=b=9 -> rsp_zero=1.
REQ-042 Div-by-zero and backpressure: op=1001, b=0 with rsp_ready held 0 for 5 cycles -> rsp_dz=1, outputs stable throughout, req_ready=0 throughout, second req_valid ignored.
REQ-043 Reset mid-mul: assert rst_n=0 two cycles into RUN -> all outputs 0 immediately, no rsp_valid after release, next add completes normally.
